// File: rtl/forward_kinematics_if.sv
`default_nettype none
// ============================================================================
// Module   : forward_kinematics_if
// Brief    : Request/result bundle between a controller and forward_kinematics.
// Revision : 1.0 - initial release
// ============================================================================
interface forward_kinematics_if;
   logic               start;
   logic        [13:0] th1;
   logic        [13:0] th2;
   logic               busy;
   logic               done;
   logic signed [13:0] x_pos;
   logic signed [13:0] y_pos;
   logic               sat;

   modport master (
      output start, th1, th2,
      input  busy, done, x_pos, y_pos, sat
   );

   modport slave (
      input  start, th1, th2,
      output busy, done, x_pos, y_pos, sat
   );
endinterface
`default_nettype wire

// File: rtl/forward_kinematics.sv
`default_nettype none
// ============================================================================
// Module   : forward_kinematics
// Brief    : Two-link SCARA forward kinematics on one shared CORDIC core,
//            two rotation passes per request under a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module forward_kinematics #(
   parameter int L1   = 2000,
   parameter int L2   = 2000,
   parameter int ITER = 14
) (
   input  logic                clk,
   input  logic                res,
   forward_kinematics_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ROT1  = 3'd1,
      S_LOAD2 = 3'd2,
      S_ROT2  = 3'd3,
      S_SUM   = 3'd4
   } state_t;

   // Link lengths pre-scaled by the CORDIC gain, 4 fractional bits
   localparam logic signed [19:0] c_mag1    = 20'((L1 * 39797) >>> 12);
   localparam logic signed [19:0] c_mag2    = 20'((L2 * 39797) >>> 12);
   localparam logic        [3:0]  c_last    = 4'(ITER - 1);
   localparam logic signed [20:0] c_pos_lim = 21'sd8191;
   localparam logic signed [20:0] c_neg_lim = -21'sd8192;

   function automatic logic [17:0] f_atan(input logic [3:0] idx);
      logic [17:0] v;
      case (idx)
         4'd0:    v = 18'd32768;
         4'd1:    v = 18'd19344;
         4'd2:    v = 18'd10221;
         4'd3:    v = 18'd5188;
         4'd4:    v = 18'd2604;
         4'd5:    v = 18'd1303;
         4'd6:    v = 18'd652;
         4'd7:    v = 18'd326;
         4'd8:    v = 18'd163;
         4'd9:    v = 18'd81;
         4'd10:   v = 18'd41;
         4'd11:   v = 18'd20;
         4'd12:   v = 18'd10;
         4'd13:   v = 18'd5;
         4'd14:   v = 18'd3;
         default: v = 18'd1;
      endcase
      return v;
   endfunction

   // Returns {clipped, value}: drop the fraction with round-half-up, then clamp
   function automatic logic [14:0] f_round_sat(input logic signed [20:0] s);
      logic signed [20:0] r;
      r = (s + 21'sd8) >>> 4;
      if (r > c_pos_lim)
         return {1'b1, 14'h1FFF};
      else if (r < c_neg_lim)
         return {1'b1, 14'h2000};
      else
         return {1'b0, r[13:0]};
   endfunction

   state_t             r_state;
   state_t             w_next;
   logic        [3:0]  r_cnt;
   logic signed [19:0] r_xr;
   logic signed [19:0] r_yr;
   logic signed [19:0] r_x1;
   logic signed [19:0] r_y1;
   logic signed [17:0] r_z;
   logic        [13:0] r_th1;
   logic        [13:0] r_th2;
   logic               r_done;
   logic               r_sat;
   logic signed [13:0] r_x_pos;
   logic signed [13:0] r_y_pos;

   logic               w_accept;
   logic               w_load;
   logic               w_rotate;
   logic        [13:0] w_ang;
   logic        [13:0] w_ang_adj;
   logic               w_fold;
   logic signed [19:0] w_mag;
   logic signed [19:0] w_xs;
   logic signed [19:0] w_ys;
   logic signed [17:0] w_atan;
   logic signed [20:0] w_sum_x;
   logic signed [20:0] w_sum_y;
   logic        [14:0] w_rx;
   logic        [14:0] w_ry;

   always_ff @(posedge clk or negedge res) begin
      if (!res)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // The done cycle is spent in IDLE but still counts as busy, so no accept there
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_load   = 1'b0;
      w_rotate = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start && !r_done) begin
               w_accept = 1'b1;
               w_load   = 1'b1;
               w_next   = S_ROT1;
            end
         end
         S_ROT1: begin
            w_rotate = 1'b1;
            if (r_cnt == c_last)
               w_next = S_LOAD2;
         end
         S_LOAD2: begin
            w_load = 1'b1;
            w_next = S_ROT2;
         end
         S_ROT2: begin
            w_rotate = 1'b1;
            if (r_cnt == c_last)
               w_next = S_SUM;
         end
         S_SUM:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_ang = r_th1 + r_th2;
      w_mag = c_mag2;
      if (r_state == S_IDLE) begin
         w_ang = bus.th1;
         w_mag = c_mag1;
      end
   end

   // Angles in the left half-plane are rotated by 180 degrees and the vector flipped
   assign w_fold    = w_ang[13] ^ w_ang[12];
   assign w_ang_adj = w_fold ? (w_ang + 14'd8192) : w_ang;

   assign w_xs    = r_xr >>> r_cnt;
   assign w_ys    = r_yr >>> r_cnt;
   assign w_atan  = $signed(f_atan(r_cnt));
   assign w_sum_x = $signed({r_x1[19], r_x1}) + $signed({r_xr[19], r_xr});
   assign w_sum_y = $signed({r_y1[19], r_y1}) + $signed({r_yr[19], r_yr});
   assign w_rx    = f_round_sat(w_sum_x);
   assign w_ry    = f_round_sat(w_sum_y);

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_cnt   <= '0;
         r_xr    <= '0;
         r_yr    <= '0;
         r_x1    <= '0;
         r_y1    <= '0;
         r_z     <= '0;
         r_th1   <= '0;
         r_th2   <= '0;
         r_done  <= 1'b0;
         r_sat   <= 1'b0;
         r_x_pos <= '0;
         r_y_pos <= '0;
      end else begin
         r_done <= (r_state == S_SUM);
         if (w_accept) begin
            r_th1 <= bus.th1;
            r_th2 <= bus.th2;
         end
         if (w_load) begin
            r_xr  <= w_fold ? -w_mag : w_mag;
            r_yr  <= '0;
            r_z   <= $signed({w_ang_adj, 4'b0000});
            r_cnt <= '0;
         end else if (w_rotate) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_z[17]) begin
               r_xr <= r_xr + w_ys;
               r_yr <= r_yr - w_xs;
               r_z  <= r_z + w_atan;
            end else begin
               r_xr <= r_xr - w_ys;
               r_yr <= r_yr + w_xs;
               r_z  <= r_z - w_atan;
            end
         end
         if (r_state == S_LOAD2) begin
            r_x1 <= r_xr;
            r_y1 <= r_yr;
         end
         if (r_state == S_SUM) begin
            r_x_pos <= $signed(w_rx[13:0]);
            r_y_pos <= $signed(w_ry[13:0]);
            r_sat   <= w_rx[14] | w_ry[14];
         end
      end
   end

   assign bus.busy  = (r_state != S_IDLE) | r_done;
   assign bus.done  = r_done;
   assign bus.x_pos = r_x_pos;
   assign bus.y_pos = r_y_pos;
   assign bus.sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_forward_kinematics.sv
`default_nettype none
// ============================================================================
// Module   : tb_forward_kinematics
// Brief    : Directed scoreboard bench for forward_kinematics (two link sizes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_forward_kinematics;

   localparam int  ITER = 14;
   localparam int  LAT  = 2 * ITER + 2;
   localparam int  TMO  = 200;
   localparam real PI   = 3.14159265358979;

   typedef struct {
      int x;
      int y;
      bit sat;
   } exp_t;

   logic               clk;
   logic               res;
   logic               sel;
   logic               start_r;
   logic        [13:0] th1_r;
   logic        [13:0] th2_r;
   logic               m_busy;
   logic               m_done;
   logic               m_sat;
   logic signed [13:0] m_x;
   logic signed [13:0] m_y;
   exp_t               sb[$];
   int                 n_tests;
   int                 n_fail;

   forward_kinematics_if bus_a ();
   forward_kinematics_if bus_b ();

   assign bus_a.start = start_r & ~sel;
   assign bus_b.start = start_r & sel;
   assign bus_a.th1   = th1_r;
   assign bus_a.th2   = th2_r;
   assign bus_b.th1   = th1_r;
   assign bus_b.th2   = th2_r;

   forward_kinematics #(.L1(2000), .L2(2000), .ITER(ITER)) u_dut_a (
      .clk (clk),
      .res (res),
      .bus (bus_a)
   );

   forward_kinematics #(.L1(5000), .L2(5000), .ITER(ITER)) u_dut_b (
      .clk (clk),
      .res (res),
      .bus (bus_b)
   );

   assign m_busy = sel ? bus_b.busy  : bus_a.busy;
   assign m_done = sel ? bus_b.done  : bus_a.done;
   assign m_sat  = sel ? bus_b.sat   : bus_a.sat;
   assign m_x    = sel ? bus_b.x_pos : bus_a.x_pos;
   assign m_y    = sel ? bus_b.y_pos : bus_a.y_pos;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model(input int len, input int t1, input int t2);
      exp_t e;
      real  a1, a2, fx, fy;
      int   ix, iy;
      a1 = 2.0 * PI * t1 / 16384.0;
      a2 = 2.0 * PI * (t1 + t2) / 16384.0;
      fx = len * $cos(a1) + len * $cos(a2);
      fy = len * $sin(a1) + len * $sin(a2);
      ix = $rtoi(fx + ((fx >= 0.0) ? 0.5 : -0.5));
      iy = $rtoi(fy + ((fy >= 0.0) ? 0.5 : -0.5));
      e.sat = 1'b0;
      if (ix > 8191) begin ix = 8191; e.sat = 1'b1; end
      if (ix < -8192) begin ix = -8192; e.sat = 1'b1; end
      if (iy > 8191) begin iy = 8191; e.sat = 1'b1; end
      if (iy < -8192) begin iy = -8192; e.sat = 1'b1; end
      e.x = ix;
      e.y = iy;
      return e;
   endfunction

   task automatic check_eq(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_near(input string tag, input int obs, input int expv);
      logic ok;
      ok = ((obs - expv) <= 2) && ((expv - obs) <= 2);
      n_tests++;
      assert (ok === 1'b1) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d +-2", tag, obs, expv);
      end
   endtask

   // Drives one request; returns just after the accepting edge with start dropped
   task automatic issue(input bit s, input int len, input int t1, input int t2,
                        input bit sync);
      if (sync) @(negedge clk);
      sel     = s;
      th1_r   = 14'(t1);
      th2_r   = 14'(t2);
      start_r = 1'b1;
      sb.push_back(model(len, t1, t2));
      @(posedge clk);
      #1 start_r = 1'b0;
   endtask

   task automatic wait_result(input string tag, input bit poke);
      int   k;
      bit   seen;
      exp_t e;
      k    = 0;
      seen = 1'b0;
      while (!seen && k < TMO) begin
         @(posedge clk);
         #1;
         k++;
         if (k == 1) check_eq({tag, ".busy_rise"}, m_busy, 1);
         if (poke && (k == 5 || k == 20)) begin
            start_r = 1'b1;
            th1_r   = th1_r + 14'd3000;
         end else begin
            start_r = 1'b0;
         end
         if (m_done) seen = 1'b1;
      end
      check_eq({tag, ".latency"}, k, LAT);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (seen) begin
            check_near({tag, ".x"}, int'(m_x), e.x);
            check_near({tag, ".y"}, int'(m_y), e.y);
            check_eq({tag, ".sat"}, m_sat, e.sat);
            check_eq({tag, ".busy_at_done"}, m_busy, 1);
            @(posedge clk);
            #1;
            check_eq({tag, ".done_pulse"}, m_done, 0);
            check_eq({tag, ".busy_fall"}, m_busy, 0);
         end
      end
   endtask

   initial begin
      bit extra;
      n_tests = 0;
      n_fail  = 0;
      sel     = 1'b0;
      start_r = 1'b0;
      th1_r   = '0;
      th2_r   = '0;
      res     = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst.busy", bus_a.busy, 0);
      check_eq("rst.done", bus_a.done, 0);
      check_eq("rst.x", bus_a.x_pos, 0);
      check_eq("rst.y", bus_a.y_pos, 0);
      check_eq("rst.sat", bus_a.sat, 0);
      check_eq("rst.b_busy", bus_b.busy, 0);
      @(negedge clk) res = 1'b1;

      issue(0, 2000, 0, 0, 1);          wait_result("home", 0);
      issue(0, 2000, 4096, 0, 1);       wait_result("q90", 0);
      issue(0, 2000, 8192, 0, 1);       wait_result("q180", 0);
      issue(0, 2000, 2048, 4096, 1);    wait_result("sum45_90", 0);
      issue(0, 2000, 0, 8192, 1);       wait_result("fold", 0);
      issue(0, 2000, 12288, 8192, 1);   wait_result("wrap", 0);
      issue(0, 2000, 1000, 3000, 1);    wait_result("misc1", 0);
      issue(0, 2000, 15000, 9000, 1);   wait_result("misc2", 0);

      issue(1, 5000, 0, 0, 1);          wait_result("sat_hi", 0);
      issue(1, 5000, 4096, 8192, 1);    wait_result("sat_clear", 0);

      issue(0, 2000, 2048, 4096, 1);    wait_result("poke", 1);
      extra = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (m_done) extra = 1'b1;
      end
      check_eq("poke.no_second_done", extra, 0);

      issue(0, 2000, 4096, 0, 1);       wait_result("b2b_first", 0);
      issue(0, 2000, 8192, 0, 0);       wait_result("b2b_second", 0);

      @(negedge clk);
      th1_r   = 14'd4096;
      th2_r   = 14'd0;
      start_r = 1'b1;
      @(posedge clk);
      #1 start_r = 1'b0;
      repeat (12) @(posedge clk);
      #1 res = 1'b0;
      #1;
      check_eq("midrst.busy", m_busy, 0);
      check_eq("midrst.done", m_done, 0);
      check_eq("midrst.x", m_x, 0);
      check_eq("midrst.y", m_y, 0);
      check_eq("midrst.sat", m_sat, 0);
      extra = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (m_done || m_busy) extra = 1'b1;
      end
      check_eq("midrst.quiet", extra, 0);
      @(negedge clk) res = 1'b1;

      issue(0, 2000, 0, 0, 1);          wait_result("post_rst", 0);

      check_eq("sb.empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/forward_kinematics.md
# forward_kinematics

Iterative CORDIC forward-kinematics engine for the two-link SCARA arm. It converts joint angles th1 and th2 into the tool-tip Cartesian position using x = L1·cos(th1) + L2·cos(th1+th2) and y = L1·sin(th1) + L2·sin(th1+th2). It sits beside the inverse-kinematics block in the FPGA controller and closes the loop from measured joint angles back to position. A single shared CORDIC core runs two passes per request under a start/done handshake.

## Interface

Parameters:

- L1, default 2000, length of link 1 in output LSBs (1 LSB = 0.1 mm); range 1..8191
- L2, default 2000, length of link 2 in output LSBs; range 1..8191
- ITER, default 14, number of CORDIC iterations per pass; range 8..16

Ports:

- clk  in  1  system clock; all state changes on the rising edge
- res  in  1  reset, asynchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- th1  in  14  joint-1 angle, binary angle: two's complement, LSB = 2π/16384, wraps naturally
- th2  in  14  joint-2 angle, same format as th1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; x_pos, y_pos and sat are valid from this cycle
- x_pos  out  14  signed X position, LSB 0.1 mm
- y_pos  out  14  signed Y position, LSB 0.1 mm
- sat  out  1  set when either output was clipped in the latest result

## Operation

- Internal datapath:
  - Vector registers xr and yr: 20-bit signed, 4 fractional bits.
  - Angle accumulator z: 18-bit (14 integer binary-angle bits plus 4 fractional bits).
  - atan table entry i = round(atan(2^-i)·2^18/(2π)); entry 0 = 32768.
- Gain pre-compensation:
  - Start magnitude m = (L·39797) >>> 12, where 39797 = round(0.6072529·2^16).
  - The pass starts with xr = m, yr = 0.
- Quadrant correction (CORDIC converges only for |angle| < 90°):
  - If angle[13] XOR angle[12], add 8192 to z (mod 2^14) and start with xr = −m.
  - Otherwise start unchanged.
- Iteration i, with d = sign of z:
  - xr ← xr − d·(yr>>>i)
  - yr ← yr + d·(xr>>>i)
  - z ← z − d·atan[i]
  - All updates use the old values.
- FSM states and transitions:
  - IDLE: busy = 0. On start = 1, latch th1 and th2, load pass 1 (L1, th1), then go to ROT1.
  - ROT1: ITER cycles, iteration counter 0..ITER−1, then go to LOAD2.
  - LOAD2: store pass-1 result as x1, y1. Load pass 2 (L2, angle th1+th2 wrapped to 14 bits), then go to ROT2.
  - ROT2: ITER cycles, then go to SUM.
  - SUM: form 21-bit sums x1+xr and y1+yr. Round (add 8, then arithmetic shift right by 4) and saturate to [−8192, 8191]. Register x_pos, y_pos and sat, pulse done, then go to IDLE.
- Boundary rules:
  - start while busy: ignored, with no queuing and no effect on the latched angles.
  - th1 and th2 changing after acceptance: no effect on the current computation.
  - th1+th2 overflow: wraps mod 2^14, which is the correct angle.
  - Outputs hold their last result until the next done.

## Timing

- Reset (res = 0, asynchronous): state goes to IDLE; busy, done, sat, x_pos and y_pos all clear to 0; internal registers clear.
- Release of reset is synchronous to clk; start can be accepted on the first edge after release.
- Latency: start is sampled at edge E0 and done is high in the cycle after edge E0 + 2·ITER + 2. That is 2·ITER + 3 cycles, or 31 cycles at ITER = 14.
- busy:
  - High from E0+1 up to and including the done cycle.
  - Low in the cycle after done.
- Throughput: a new start can be accepted in the first cycle busy is low after done, so the peak rate is one result per 2·ITER + 4 cycles.
- done lasts exactly one cycle. x_pos, y_pos and sat update on the same edge that raises done.
- Accuracy: |error| ≤ 2 LSB per axis for ITER = 14.
- Reset asserted mid-computation: immediate abort, no done pulse, all outputs forced to reset values.

## Test plan

- Home pose: L1 = L2 = 2000, th1 = 0, th2 = 0, pulse start → done exactly 31 cycles later; x_pos = 4000 ±2, y_pos = 0 ±2, sat = 0.
- Quadrant and sum:
  - th1 = 4096 (90°), th2 = 0 → x = 0 ±2, y = 4000 ±2.
  - th1 = 8192 (180°), th2 = 0 → x = −4000 ±2, y = 0 ±2.
  - th1 = 2048, th2 = 4096 → x = 0 ±2, y = 2828 ±2.
- Fold and wrap:
  - th1 = 0, th2 = 8192 → x = 0 ±2, y = 0 ±2.
  - th1 = 12288, th2 = 8192 (sum wraps) → x = 0 ±2, y = 0 ±2.
- Saturation: L1 = L2 = 5000, th1 = th2 = 0 → x_pos = 8191, y_pos = 0, sat = 1. Next request with th1 = 4096, th2 = 8192 → x = 0, y = 0, sat = 0.
- Handshake:
  - Pulse start again at cycles 5 and 20 of a run → ignored; a single done at cycle 31 with the first request's result.
  - Change th1 mid-run → result unchanged.
  - start in the first cycle with busy = 0 after done → accepted.
- Reset mid-run: drive res = 0 at cycle 12 → busy, done, x_pos, y_pos and sat go to 0 immediately with no done pulse. After release, a fresh request completes normally in 31 cycles.
